// File: rtl/shift_normalizer_pkg.sv
// Shared definitions for the shift normalizer: FSM encoding, data width
// and the per-step shift-size table used by the iterative datapath.
package shift_normalizer_pkg;

   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Entry [k] is the shift size tried on BUSY step k.
   localparam logic [3:0][4:0] STEP_TABLE = {5'd1, 5'd2, 5'd4, 5'd8};

   function automatic logic [4:0] step_size(input logic [1:0] idx);
      return STEP_TABLE[idx];
   endfunction

   // Count bit contributed by step k is log2(step size) = 3 - k.
   function automatic logic [3:0] step_bit(input logic [1:0] idx);
      return 4'b1000 >> idx;
   endfunction

endpackage

// File: rtl/shift_normalizer_norm_step.sv
// Single test-and-shift stage: if the s bits at the leading (Dir=0) or
// trailing (Dir=1) end are all zero, shift them out and report a hit.
module norm_step
   import shift_normalizer_pkg::*;
(
   input  logic [DATA_W-1:0] work_i,
   input  logic              dir_i,
   input  logic [4:0]        step_i,
   output logic [DATA_W-1:0] work_o,
   output logic              hit_o
);

   logic [4:0]        rem_s;
   logic [DATA_W-1:0] probe_s;

   // Isolate the s bits under test by shifting the rest away, then shift on a hit.
   always_comb begin
      rem_s   = 5'd16 - step_i;
      probe_s = 16'h0000;
      work_o  = work_i;
      if (dir_i == 1'b0) begin
         probe_s = work_i >> rem_s;
      end else begin
         probe_s = work_i << rem_s;
      end
      hit_o = (probe_s == 16'h0000);
      if (hit_o && (dir_i == 1'b0)) begin
         work_o = work_i << step_i;
      end else if (hit_o) begin
         work_o = work_i >> step_i;
      end else begin
         work_o = work_i;
      end
   end

endmodule

// File: rtl/shift_normalizer.sv
// Iterative 16-bit normalizer: counts leading (Dir=0) or trailing (Dir=1)
// zeros in four fixed BUSY steps and presents the shifted value and count.
module shift_normalizer
   import shift_normalizer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] In,
   input  logic              Dir,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] Out,
   output logic [3:0]        Cnt,
   output logic              Zero
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] work_q, work_d;
   logic              dir_q, dir_d;
   logic              zero_q, zero_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [1:0]        step_q, step_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic [3:0]        out_cnt_q, out_cnt_d;
   logic              out_zero_q, out_zero_d;

   logic [DATA_W-1:0] step_work_s;
   logic              step_hit_s;

   norm_step u_norm_step (
      .work_i (work_q),
      .dir_i  (dir_q),
      .step_i (step_size(step_q)),
      .work_o (step_work_s),
      .hit_o  (step_hit_s)
   );

   // Next-state and datapath; result registers are only non-zero in DONE.
   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      dir_d       = dir_q;
      zero_d      = zero_q;
      cnt_d       = cnt_q;
      step_d      = step_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      out_cnt_d   = out_cnt_q;
      out_zero_d  = out_zero_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               state_d    = ST_BUSY;
               work_d     = In;
               dir_d      = Dir;
               zero_d     = (In == 16'h0000);
               cnt_d      = 4'd0;
               step_d     = 2'd0;
               in_ready_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // A zero operand would "hit" every step; the Zero flag masks that.
            if (step_hit_s && !zero_q) begin
               work_d = step_work_s;
               cnt_d  = cnt_q | step_bit(step_q);
            end else begin
               work_d = work_q;
            end
            if (step_q == 2'd3) begin
               state_d     = ST_DONE;
               step_d      = 2'd0;
               out_valid_d = 1'b1;
               out_d       = work_d;
               out_cnt_d   = cnt_d;
               out_zero_d  = zero_q;
            end else begin
               step_d = step_q + 2'd1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
               out_d       = 16'h0000;
               out_cnt_d   = 4'd0;
               out_zero_d  = 1'b0;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            work_d      = 16'h0000;
            dir_d       = 1'b0;
            zero_d      = 1'b0;
            cnt_d       = 4'd0;
            step_d      = 2'd0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_d       = 16'h0000;
            out_cnt_d   = 4'd0;
            out_zero_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         work_q      <= 16'h0000;
         dir_q       <= 1'b0;
         zero_q      <= 1'b0;
         cnt_q       <= 4'd0;
         step_q      <= 2'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= 16'h0000;
         out_cnt_q   <= 4'd0;
         out_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         dir_q       <= dir_d;
         zero_q      <= zero_d;
         cnt_q       <= cnt_d;
         step_q      <= step_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         out_cnt_q   <= out_cnt_d;
         out_zero_q  <= out_zero_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Out       = out_q;
   assign Cnt       = out_cnt_q;
   assign Zero      = out_zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer: a reference count/shift model fills
// the expected queue at accept time and results are popped when out_valid rises.
module tb_shift_normalizer;

   typedef struct packed {
      logic [15:0] op;
      logic        dir;
      logic [15:0] out;
      logic [3:0]  cnt;
      logic        zero;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] In = 16'h0000;
   logic        Dir = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] Out;
   logic [3:0]  Cnt;
   logic        Zero;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_miss = 0;

   shift_normalizer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .In        (In),
      .Dir       (Dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Out       (Out),
      .Cnt       (Cnt),
      .Zero      (Zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] op, input logic dir);
      exp_t e;
      int   n;
      n = 0;
      if (op != 16'h0000) begin
         if (dir == 1'b0) begin
            while (op[15 - n] == 1'b0) n++;
         end else begin
            while (op[n] == 1'b0) n++;
         end
      end
      e.op   = op;
      e.dir  = dir;
      e.cnt  = 4'(n);
      e.zero = (op == 16'h0000);
      e.out  = (dir == 1'b0) ? (op << n) : (op >> n);
      return e;
   endfunction

   // Offer one operand, check latency and idle outputs, hold the result for
   // 'hold' cycles with out_ready low, then consume and verify the result.
   task automatic run_op(input logic [15:0] op, input logic dir, input int hold);
      exp_t e;
      int   edges;
      @(negedge clk);
      chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      In       = op;
      Dir      = dir;
      exp_q.push_back(model(op, dir));
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      // Keep offering a different operand while busy; it must be ignored.
      In  = ~op;
      Dir = ~dir;
      while (!out_valid && edges < 12) begin
         chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
         chk("busy_out_zeroed", {11'd0, Zero, Cnt, Out}, 32'd0);
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("latency_edges", edges, 32'd5);
      if (!out_valid) begin
         exp_q.delete();
         return;
      end
      e = exp_q[0];
      for (int h = 0; h < hold; h++) begin
         chk("hold_out", {16'd0, Out}, {16'd0, e.out});
         chk("hold_cnt_zero", {27'd0, Zero, Cnt}, {27'd0, e.zero, e.cnt});
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      e = exp_q.pop_front();
      chk("result_out", {16'd0, Out}, {16'd0, e.out});
      chk("result_cnt", {28'd0, Cnt}, {28'd0, e.cnt});
      chk("result_zero", {31'd0, Zero}, {31'd0, e.zero});
      if (e.op != 16'h0000) begin
         chk("round_trip", {16'd0, (e.dir ? (Out << Cnt) : (Out >> Cnt))}, {16'd0, e.op});
      end else begin
         chk("zero_cnt", {28'd0, Cnt}, 32'd0);
      end
      // Offer a new operand in the consume cycle; it must not be taken.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("after_consume_state", {30'd0, in_ready, out_valid}, 32'h2);
      chk("after_consume_out", {11'd0, Zero, Cnt, Out}, 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {30'd0, in_ready, out_valid}, 32'h2);
      chk("reset_out", {11'd0, Zero, Cnt, Out}, 32'd0);
      rst_n = 1'b1;

      run_op(16'h0001, 1'b0, 0);
      run_op(16'h8000, 1'b1, 0);
      run_op(16'h00F0, 1'b0, 1);
      run_op(16'h00F0, 1'b1, 0);
      run_op(16'h0000, 1'b0, 0);
      run_op(16'h0000, 1'b1, 2);
      run_op(16'h8001, 1'b0, 3);
      run_op(16'h8001, 1'b1, 0);
      run_op(16'h0001, 1'b1, 0);
      run_op(16'h8000, 1'b0, 0);

      // Reset during BUSY step 2: the accepted operation must vanish.
      @(negedge clk);
      in_valid = 1'b1;
      In       = 16'h0010;
      Dir      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("reset_busy_state", {30'd0, in_ready, out_valid}, 32'h2);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("reset_busy_no_result", {31'd0, out_valid}, 32'd0);
      end

      for (int i = 0; i < 40; i++) begin
         logic [15:0] r;
         r = 16'($urandom);
         if (i % 4 == 0) r = r >> $urandom_range(15, 0);
         if (i % 4 == 1) r = r << $urandom_range(15, 0);
         run_op(r, 1'($urandom_range(1, 0)), (i % 3 == 0) ? 1 : 0);
      end

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/shift_normalizer.md
SHIFT_NORMALIZER -- requirements
Module: shift_normalizer

Interface
REQ-001 The module SHALL have no parameters; the data width is fixed at 16 bits.
REQ-002 The module SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low.
REQ-005 in_valid  input  1  the upstream stage offers an operand.
REQ-006 in_ready  output  1  the block can accept an operand; high only in IDLE.
REQ-007 In  input  16  operand to normalize.
REQ-008 Dir  input  1  0 = count leading zeros and normalize left; 1 = count trailing zeros and normalize right (logical).
REQ-009 out_valid  output  1  result available; high only in DONE.
REQ-010 out_ready  input  1  the downstream stage accepts the result.
REQ-011 Out  output  16  normalized value.
REQ-012 Cnt  output  4  number of bit positions shifted.
REQ-013 Zero  output  1  the captured operand was 0x0000.

Function
REQ-014 The block SHALL implement the inverse of the barrel shifter: it SHALL produce the shift count instead of consuming it.
  - Dir=0: shifting Out right logically by Cnt SHALL reproduce In.
  - Dir=1: shifting Out left logically by Cnt SHALL reproduce In.
REQ-015 States SHALL be IDLE, BUSY, DONE.
  - IDLE→BUSY on in_valid&&in_ready.
  - BUSY→DONE after exactly 4 BUSY cycles.
  - DONE→IDLE on out_valid&&out_ready.
REQ-016 On accept, the block SHALL latch In, Dir, and Zero=(In==0), clear the working count, and set the step index to 0.
REQ-017 BUSY step k SHALL use step size s = 8, 4, 2, 1 for k = 0..3.
  - Dir=0: if the top s bits of the working register are all zero, shift it left by s and set count bit log2(s).
  - Dir=1: apply the same rule to the bottom s bits, shifting right by s.
REQ-018 Latency SHALL be fixed: out_valid SHALL rise on the 5th rising edge after the accept edge (accept edge counted as edge 1), independent of data.
REQ-019 A zero operand SHALL still take 4 BUSY cycles and SHALL give Out=0x0000, Cnt=0, Zero=1; all four zero-tests SHALL be suppressed when Zero=1.
REQ-020 An operand with the extreme bit already set SHALL give Cnt=0 and Out=In: bit 15 for Dir=0, bit 0 for Dir=1.
REQ-021 While out_valid=1 and out_ready=0, Out, Cnt and Zero SHALL hold stable.
REQ-022 in_ready SHALL be 0 in BUSY and DONE; in_valid SHALL be ignored in those states.
REQ-023 The block SHALL NOT accept a new operand in the cycle the result is consumed; the minimum initiation interval is 6 cycles.
REQ-024 Out, Cnt and Zero SHALL read 0 whenever out_valid=0.

Reset
REQ-025 On a rising edge with rst_n=0, the block SHALL enter IDLE.
  - in_ready SHALL be 1 and out_valid SHALL be 0.
  - Out, Cnt and Zero SHALL be 0.
  - Internal working register, count and step index SHALL be 0.
REQ-026 Reset in BUSY or DONE SHALL discard the operation in progress; no result SHALL ever be presented for it.

Structure
REQ-027 The state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and the step-size table {8,4,2,1} SHALL live in the shared processor package.
REQ-028 One combinational sub-module, norm_step, SHALL perform a single test-and-shift.
  - Inputs: working register, Dir, step size.
  - Outputs: next register, hit flag.
REQ-029 Only one norm_step instance SHALL exist, reused across the 4 BUSY cycles.

Verification
REQ-030 In=0x0001, Dir=0 → Out=0x8000, Cnt=15, Zero=0; out_valid high exactly 5 edges after accept.
REQ-031 In=0x8000, Dir=1 → Out=0x0001, Cnt=15.
REQ-032 In=0x00F0 → Dir=0 gives Out=0xF000, Cnt=8; Dir=1 gives Out=0x000F, Cnt=4.
REQ-033 In=0x0000 → Zero=1, Out=0x0000, Cnt=0.
REQ-034 In=0x8001, Dir=0, with out_ready held low 3 cycles → Out=0x8001, Cnt=0 stable and in_ready=0 throughout; after release, the next operand is accepted the following cycle.
REQ-035 rst_n low for one edge during BUSY step 2 → on the next cycle in_ready=1, out_valid=0, and no result appears.
REQ-036 Random operands with both Dir values, round-tripped through the existing shifter → the shifter output SHALL equal In for every non-zero operand.
